// File: rtl/nn_infer_ctrl.sv
// nn_infer_ctrl: binary-image nearest-class scorer.
//
// Loads a 64-pixel binary image as eight packed bytes, then for each class
// streams the 64 class weights from an external ROM, accumulates the weights
// of the set pixels and keeps the best-scoring class. The winning class index
// is presented on digit_bcd once all classes are scored.
//
// Parameters
//   N_CLASSES   number of classes scored (ROM holds 64 weights per class)
//   ACC_W       signed accumulator width (>= 8)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous soft abort back to IDLE (wins over pix_valid)
//   pix_data     8 packed pixels, bit j of byte i is pixel 8*i+j
//   pix_valid    pix_data is valid
//   pix_ready    byte accepted on an edge where pix_valid && pix_ready
//   w_addr       weight ROM address (class*64 + pixel)
//   w_rd         weight ROM read strobe
//   w_data       signed weight, valid the cycle after its w_rd
//   busy         high while scoring
//   digit_bcd    winning class index
//   digit_valid  digit_bcd holds a completed result
//
// Configuration
//   NNCTRL_ACC_SAT_EN  when defined each accumulation saturates to the signed
//                      ACC_W range; otherwise the accumulator wraps.

module nn_infer_ctrl #(
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned ACC_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [9:0] w_addr,
  output logic       w_rd,
  input  logic [7:0] w_data,
  output logic       busy,
  output logic [3:0] digit_bcd,
  output logic       digit_valid
);

  localparam int unsigned CLS_W  = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam int unsigned STEP_W = 7;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 3;

  // Per-class step schedule: 0..63 issue reads, 64 drain, 65 marks compare.
  // 66 is a parking step after the last class while its compare completes.
  localparam logic [STEP_W-1:0] STEP_LAST_RD = STEP_W'(63);
  localparam logic [STEP_W-1:0] STEP_DRAIN   = STEP_W'(64);
  localparam logic [STEP_W-1:0] STEP_CMP     = STEP_W'(65);
  localparam logic [STEP_W-1:0] STEP_PARK    = STEP_W'(66);
  localparam logic [CLS_W-1:0]  CLS_LAST     = CLS_W'(N_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [63:0]              pix_q, pix_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic [CLS_W-1:0]         cls_q, cls_d;
  logic                     w_rd_q, w_rd_d;
  logic [ADDR_W-1:0]        w_addr_q, w_addr_d;
  logic                     rdpix_q, rdpix_d;
  logic                     dv_q, dv_d;
  logic                     dpix_q, dpix_d;
  logic                     mark_q, mark_d;
  logic [CLS_W-1:0]         mark_cls_q, mark_cls_d;
  logic                     mark_last_q, mark_last_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  best_q, best_d;
  logic [CLS_W-1:0]         best_idx_q, best_idx_d;
  logic [3:0]               digit_bcd_q, digit_bcd_d;
  logic                     digit_valid_q, digit_valid_d;
  logic                     busy_q, busy_d;
  logic                     ready_en_q;

  logic                     accept_c;
  logic                     take_c;
  logic [CLS_W-1:0]         final_idx_c;

  // One accumulation step: sign-extended weight added with wrap or clamp.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic [7:0]              w
  );
`ifdef NNCTRL_ACC_SAT_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-7){w[7]}}, w};
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return s[ACC_W-1:0];
`else
    return a + {{(ACC_W-8){w[7]}}, w};
`endif
  endfunction

  // Ready is held low during reset and the first edge after it.
  assign pix_ready = ready_en_q && (state_q != S_RUN) && !clear;
  assign accept_c  = pix_valid && pix_ready;

  // Strictly-greater replacement keeps ties on the lowest class index.
  assign take_c      = mark_q && ((mark_cls_q == '0) || (acc_q > best_q));
  assign final_idx_c = take_c ? mark_cls_q : best_idx_q;

  assign w_addr      = w_addr_q;
  assign w_rd        = w_rd_q;
  assign busy        = busy_q;
  assign digit_bcd   = digit_bcd_q;
  assign digit_valid = digit_valid_q;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pix_q         <= '0;
      step_q        <= '0;
      cls_q         <= '0;
      w_rd_q        <= 1'b0;
      w_addr_q      <= '0;
      rdpix_q       <= 1'b0;
      dv_q          <= 1'b0;
      dpix_q        <= 1'b0;
      mark_q        <= 1'b0;
      mark_cls_q    <= '0;
      mark_last_q   <= 1'b0;
      acc_q         <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      digit_bcd_q   <= '0;
      digit_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      ready_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pix_q         <= pix_d;
      step_q        <= step_d;
      cls_q         <= cls_d;
      w_rd_q        <= w_rd_d;
      w_addr_q      <= w_addr_d;
      rdpix_q       <= rdpix_d;
      dv_q          <= dv_d;
      dpix_q        <= dpix_d;
      mark_q        <= mark_d;
      mark_cls_q    <= mark_cls_d;
      mark_last_q   <= mark_last_d;
      acc_q         <= acc_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      digit_bcd_q   <= digit_bcd_d;
      digit_valid_q <= digit_valid_d;
      busy_q        <= busy_d;
      ready_en_q    <= 1'b1;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pix_d         = pix_q;
    step_d        = step_q;
    cls_d         = cls_q;
    w_rd_d        = 1'b0;
    w_addr_d      = w_addr_q;
    rdpix_d       = 1'b0;
    dv_d          = w_rd_q;
    dpix_d        = rdpix_q;
    mark_d        = 1'b0;
    mark_cls_d    = mark_cls_q;
    mark_last_d   = mark_last_q;
    acc_d         = acc_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    digit_bcd_d   = digit_bcd_q;
    digit_valid_d = digit_valid_q;
    busy_d        = 1'b0;

    // Weight returned this cycle belongs to the read issued two cycles ago.
    if (dv_q && dpix_q) begin
      acc_d = acc_add(acc_q, w_data);
    end

    // Compare cycle: fold the finished class into best, restart acc.
    if (mark_q) begin
      acc_d = '0;
      if (take_c) begin
        best_d     = acc_q;
        best_idx_d = mark_cls_q;
      end
    end

    unique case (state_q)
      S_IDLE, S_LOAD, S_DONE: begin
        if (accept_c) begin
          pix_d[{cnt_q, 3'b000} +: 8] = pix_data;
          cnt_d         = cnt_q + CNT_W'(1);
          digit_valid_d = 1'b0;
          if (cnt_q == CNT_W'(7)) begin
            state_d = S_RUN;
            step_d  = '0;
            cls_d   = '0;
            acc_d   = '0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        if (step_q <= STEP_LAST_RD) begin
          w_rd_d   = 1'b1;
          w_addr_d = ADDR_W'({cls_q, step_q[5:0]});
          rdpix_d  = pix_q[step_q[5:0]];
          step_d   = step_q + STEP_W'(1);
        end else if (step_q == STEP_DRAIN) begin
          step_d = STEP_CMP;
        end else if (step_q == STEP_CMP) begin
          mark_d      = 1'b1;
          mark_cls_d  = cls_q;
          mark_last_d = (cls_q == CLS_LAST);
          if (cls_q == CLS_LAST) begin
            step_d = STEP_PARK;
          end else begin
            step_d = '0;
            cls_d  = cls_q + CLS_W'(1);
          end
        end

        // Last class compared: publish the result as DONE is entered.
        if (mark_q && mark_last_q) begin
          state_d       = S_DONE;
          busy_d        = 1'b0;
          digit_valid_d = 1'b1;
          digit_bcd_d   = 4'(final_idx_c);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Soft abort discards the image and scoring; digit_bcd is kept.
    if (clear) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      step_d        = '0;
      cls_d         = '0;
      w_rd_d        = 1'b0;
      rdpix_d       = 1'b0;
      dv_d          = 1'b0;
      dpix_d        = 1'b0;
      mark_d        = 1'b0;
      mark_last_d   = 1'b0;
      acc_d         = '0;
      best_d        = '0;
      best_idx_d    = '0;
      digit_valid_d = 1'b0;
      busy_d        = 1'b0;
    end
  end

endmodule

// File: doc/nn_infer_ctrl.md
NN_INFER_CTRL -- requirements
Module: nn_infer_ctrl

Interface
REQ-001 SHALL have parameter N_CLASSES, default 10: number of output classes scored.
REQ-002 SHALL have parameter ACC_W, default 16: signed accumulator width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous soft abort.
REQ-006 SHALL have port pix_data, input, 8 bits: packed binary pixels, 8 per byte.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_data is valid.
REQ-008 SHALL have port pix_ready, output, 1 bit: controller accepts a byte.
REQ-009 SHALL have port w_addr, output, 10 bits: weight ROM address.
REQ-010 SHALL have port w_rd, output, 1 bit: weight read strobe.
REQ-011 SHALL have port w_data, input, 8 bits: signed weight, valid exactly 1 cycle after its w_rd.
REQ-012 SHALL have port busy, output, 1 bit: high while scoring is in progress.
REQ-013 SHALL have port digit_bcd, output, 4 bits: winning class index.
REQ-014 SHALL have port digit_valid, output, 1 bit: digit_bcd holds a completed result.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, DONE: IDLE->LOAD on the first accepted byte; LOAD->RUN on the 8th accepted byte; RUN->DONE after the last class is scored; DONE->LOAD on the next accepted byte.
REQ-016 SHALL accept a byte on any edge where pix_valid && pix_ready; pix_ready = (IDLE|LOAD|DONE) && !clear.
REQ-017 SHALL map byte i (0..7), bit j to pixel p = 8*i + j, giving a 64-pixel image stored internally.
REQ-018 SHALL, in RUN, score each class c = 0..N_CLASSES-1 in order as follows:
- issue 64 reads, w_rd=1, w_addr = c*64 + p for p = 0..63 on consecutive cycles;
- then 1 drain cycle;
- then 1 compare/clear cycle.
This gives 66 cycles per class.
REQ-019 SHALL, each cycle after a read, add sign-extended w_data to acc when pixel p is 1, and add 0 otherwise.
REQ-020 SHALL clear acc to 0 at the start of each class.
REQ-021 SHALL, in the compare cycle, replace best value and best index when acc > best (strictly greater), so ties resolve to the lowest index; class 0 always loads best.
REQ-022 SHALL, on entering DONE, set digit_bcd to the best index and digit_valid to 1, exactly N_CLASSES*66+1 edges after the edge accepting the 8th byte (661 for defaults).
REQ-023 SHALL hold digit_valid and digit_bcd in DONE until the first byte of the next image is accepted; digit_valid then falls on that edge and digit_bcd holds its value.
REQ-024 SHALL keep busy = 1 exactly while in RUN, and w_rd = 0 outside RUN issue cycles.
REQ-025 SHALL keep pix_ready = 0 in RUN; pix_valid in RUN SHALL be ignored with no loss of state.
REQ-026 SHALL, on clear = 1 in any state, go to IDLE next edge, discarding the partial image and accumulators; digit_valid = 0, digit_bcd unchanged.
REQ-027 SHALL give clear priority when clear and pix_valid coincide: no byte is accepted.
REQ-028 SHALL sign-extend w_data to ACC_W bits; without the configuration macro, acc wraps modulo 2^ACC_W.

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously force: state IDLE, digit_bcd = 0, digit_valid = 0, busy = 0, w_rd = 0, w_addr = 0, acc, best and byte count = 0.
REQ-030 SHALL hold pix_ready = 1 from the first edge after rst_n rises; reset mid-RUN aborts with no result.

Configuration
REQ-031 SHALL, with NNCTRL_ACC_SAT_EN defined, clamp each accumulation to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; without it, acc wraps per REQ-028.

Verification
REQ-032 SHALL cover: all-zero image, any ROM -> digit_bcd = 0, digit_valid rises 661 edges after 8th byte, busy high 660 cycles.
REQ-033 SHALL cover: all-ones image, ROM w = 1 for addr 448..511 (class 7), else 0 -> digit_bcd = 7.
REQ-034 SHALL cover: pixel 0 only set, w(3,0) = w(5,0) = 50, others -20 -> digit_bcd = 3 (tie to lowest).
REQ-035 SHALL cover: rst_n low at cycle 200 of RUN -> all outputs 0 immediately; after release, a new 8-byte image completes normally.
REQ-036 SHALL cover: pix_valid held high continuously through RUN -> no extra bytes accepted; clear during LOAD after 5 bytes -> next 8 bytes form a fresh image.
REQ-037 SHALL cover: ACC_W = 10, all-ones image, class 1 w = 127, others 0:
- with NNCTRL_ACC_SAT_EN: acc1 = 511, digit_bcd = 1;
- without it: wrapped acc1 = 8128 mod 1024 = -64 (as signed), digit_bcd = 0.
